// File: rtl/weight_tile_router.sv
// weight_tile_router: per-lane address-window router behind the weight controller.
// Holds one [start,end) window per PE lane and scans weight SRAM from the lowest start
// to the highest end. Each returned word is pushed into every lane FIFO whose window
// covers its address. Once the scan is done, all lane FIFOs drain in parallel on pop requests.
module weight_tile_router #(
    parameter int COUNT      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_nrst,
    input  logic                        i_reg_clear,
    input  logic                        i_addr_write_en,
    input  logic [COUNT-1:0]            i_id,
    input  logic [ADDR_WIDTH-1:0]       i_start_addr,
    input  logic [ADDR_WIDTH-1:0]       i_end_addr,
    input  logic                        i_route_en,
    input  logic                        i_pop_en,
    output logic                        o_sram_re,
    output logic [ADDR_WIDTH-1:0]       o_sram_addr,
    input  logic [DATA_WIDTH-1:0]       i_sram_data,
    output logic [COUNT*DATA_WIDTH-1:0] o_data,
    output logic [COUNT-1:0]            o_valid,
    output logic                        o_fifo_pop_ready,
    output logic                        o_fifo_empty,
    output logic                        o_overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] scan_lo;
    logic [ADDR_WIDTH-1:0] scan_hi;

    logic [COUNT-1:0]      win_vld;
    logic [ADDR_WIDTH-1:0] win_start [COUNT];
    logic [ADDR_WIDTH-1:0] win_end   [COUNT];
    logic [COUNT-1:0]      sel;
    logic                  win_we;

    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;

    logic [COUNT-1:0]      hit;
    logic [COUNT-1:0]      push;
    logic [COUNT-1:0]      drop;
    logic [COUNT-1:0]      pop;
    logic                  pop_fire;
    logic                  all_cnt_zero;

    logic [PTR_W-1:0]      wr_ptr [COUNT];
    logic [PTR_W-1:0]      rd_ptr [COUNT];
    logic [CNT_W-1:0]      cnt    [COUNT];
    logic [DATA_WIDTH-1:0] fifo_mem [COUNT][DEPTH];

    // True when address a lies inside [s,e); an empty window (e<=s) never matches.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] s,
                                       input logic [ADDR_WIDTH-1:0] e);
        return (s <= a) && (a < e);
    endfunction

    // Decode the binary lane index; indices >= COUNT select no lane.
    always_comb begin
        sel = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (int'(i_id) == k) sel[k] = 1'b1;
        end
        win_we = i_addr_write_en && (state == ST_IDLE) && !i_reg_clear;
    end

    // Window valid bits and the overall scan bounds (widest bounds are kept on rewrite).
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            win_vld <= '0;
            scan_lo <= '1;
            scan_hi <= '0;
        end else if (i_reg_clear) begin
            win_vld <= '0;
            scan_lo <= '1;
            scan_hi <= '0;
        end else if (win_we && (sel != '0)) begin
            win_vld <= win_vld | sel;
            if (i_end_addr > i_start_addr) begin
                if (i_start_addr < scan_lo) scan_lo <= i_start_addr;
                if (i_end_addr > scan_hi)   scan_hi <= i_end_addr;
            end
        end
    end

    // Window bound storage; meaning is qualified by win_vld so no reset is needed.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < COUNT; k++) begin
            if (win_we && sel[k]) begin
                win_start[k] <= i_start_addr;
                win_end[k]   <= i_end_addr;
            end
        end
    end

    // Scan sequencer: IDLE -> SCAN -> DRAIN -> READY -> IDLE.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else if (i_reg_clear) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_route_en) begin
                        if (scan_lo >= scan_hi) begin
                            state <= ST_READY;
                        end else begin
                            state <= ST_SCAN;
                            addr  <= scan_lo;
                        end
                    end
                end
                ST_SCAN: begin
                    if (addr == (scan_hi - ADDR_ONE)) state <= ST_DRAIN;
                    else                              addr  <= addr + ADDR_ONE;
                end
                ST_DRAIN: state <= ST_READY;
                default: begin
                    if (all_cnt_zero) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sram_re        = (state == ST_SCAN);
    assign o_sram_addr      = o_sram_re ? addr : '0;
    assign o_fifo_pop_ready = (state == ST_READY);

    // ---- stage p0: read address travels with its read enable to meet the SRAM data ----
    // Read-valid tag for the word returning from SRAM next cycle.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)          vld_p0 <= 1'b0;
        else if (i_reg_clear) vld_p0 <= 1'b0;
        else                  vld_p0 <= o_sram_re;
    end

    // Address of the outstanding read, qualified by vld_p0.
    always_ff @(posedge i_clk) begin
        addr_p0 <= addr;
    end

    // ---- stage p1: window compare against returned data, push/pop decisions ----
    // Per-lane hit, push, drop and pop strobes.
    always_comb begin
        hit      = '0;
        push     = '0;
        drop     = '0;
        pop      = '0;
        pop_fire = (state == ST_READY) && i_pop_en && !i_reg_clear;
        for (int k = 0; k < COUNT; k++) begin
            hit[k]  = vld_p0 && win_vld[k] && in_window(addr_p0, win_start[k], win_end[k]);
            push[k] = hit[k] && (cnt[k] != CNT_FULL) && !i_reg_clear;
            drop[k] = hit[k] && (cnt[k] == CNT_FULL);
            pop[k]  = pop_fire && (cnt[k] != '0);
        end
    end

    // Empty flag looks through pops issued this cycle so it drops with the last pop.
    always_comb begin
        o_fifo_empty = 1'b1;
        all_cnt_zero = 1'b1;
        for (int k = 0; k < COUNT; k++) begin
            if (cnt[k] != '0) all_cnt_zero = 1'b0;
            if ((cnt[k] != '0) && !(pop[k] && (cnt[k] == CNT_ONE))) o_fifo_empty = 1'b0;
        end
    end

    // Lane FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int k = 0; k < COUNT; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
            o_overflow <= 1'b0;
        end else if (i_reg_clear) begin
            for (int k = 0; k < COUNT; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
            o_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < COUNT; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                    cnt[k]    <= cnt[k] + CNT_ONE;
                end else if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                    cnt[k]    <= cnt[k] - CNT_ONE;
                end
            end
            if (drop != '0) o_overflow <= 1'b1;
        end
    end

    // Lane FIFO storage.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < COUNT; k++) begin
            if (push[k]) fifo_mem[k][wr_ptr[k]] <= i_sram_data;
        end
    end

    // ---- stage p2: popped words presented on the output lanes ----
    // Registered pop results; lanes not popped keep their last word with o_valid low.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_valid <= '0;
            o_data  <= '0;
        end else if (i_reg_clear) begin
            o_valid <= '0;
            o_data  <= '0;
        end else begin
            o_valid <= pop;
            for (int k = 0; k < COUNT; k++) begin
                if (pop[k]) o_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_mem[k][rd_ptr[k]];
            end
        end
    end

endmodule

// File: tb/tb_weight_tile_router.sv
// Bench for weight_tile_router: directed scenarios with literal expectations plus
// randomized window tables, SRAM contents and pop patterns, all checked every cycle
// against a transaction-level model of the router.
module tb_weight_tile_router;
    localparam int COUNT = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_SCAN  = 1;
    localparam int PH_READY = 2;

    logic                  i_clk = 1'b0;
    logic                  i_nrst = 1'b0;
    logic                  i_reg_clear = 1'b0;
    logic                  i_addr_write_en = 1'b0;
    logic [COUNT-1:0]      i_id = '0;
    logic [AW-1:0]         i_start_addr = '0;
    logic [AW-1:0]         i_end_addr = '0;
    logic                  i_route_en = 1'b0;
    logic                  i_pop_en = 1'b0;
    logic                  o_sram_re;
    logic [AW-1:0]         o_sram_addr;
    logic [DW-1:0]         i_sram_data = '0;
    logic [COUNT*DW-1:0]   o_data;
    logic [COUNT-1:0]      o_valid;
    logic                  o_fifo_pop_ready;
    logic                  o_fifo_empty;
    logic                  o_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] mem [256];

    weight_tile_router #(.COUNT(COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
        .i_addr_write_en(i_addr_write_en), .i_id(i_id),
        .i_start_addr(i_start_addr), .i_end_addr(i_end_addr),
        .i_route_en(i_route_en), .i_pop_en(i_pop_en),
        .o_sram_re(o_sram_re), .o_sram_addr(o_sram_addr), .i_sram_data(i_sram_data),
        .o_data(o_data), .o_valid(o_valid), .o_fifo_pop_ready(o_fifo_pop_ready),
        .o_fifo_empty(o_fifo_empty), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous SRAM: data appears the cycle after the read.
    always @(posedge i_clk) begin
        if (o_sram_re) i_sram_data <= mem[o_sram_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_phase;
    int            m_c;
    int            m_len;
    int            m_lo;
    int            m_hi;
    bit            m_v [COUNT];
    int            m_s [COUNT];
    int            m_e [COUNT];
    logic [DW-1:0] m_q [COUNT][$];
    bit            m_ovf;
    bit [COUNT-1:0] e_valid;
    logic [DW-1:0] e_data [COUNT];
    bit            e_re;
    int            e_addr;

    task automatic model_clear();
        m_phase = PH_IDLE;
        m_lo = 255;
        m_hi = 0;
        m_c = 0;
        m_len = 0;
        m_ovf = 1'b0;
        for (int k = 0; k < COUNT; k++) begin
            m_v[k] = 1'b0;
            m_q[k].delete();
        end
    endtask

    // Whole-scan result: each address in [lo,hi) goes to every covering lane in order.
    task automatic model_fill();
        for (int a = m_lo; a < m_hi; a++) begin
            for (int k = 0; k < COUNT; k++) begin
                if (m_v[k] && m_s[k] <= a && a < m_e[k]) begin
                    if (m_q[k].size() < DEPTH) m_q[k].push_back(mem[a]);
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    always @(posedge i_clk) begin
        bit all_empty;
        e_valid = '0;
        if (!i_nrst || i_reg_clear) begin
            model_clear();
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (i_addr_write_en && int'(i_id) < COUNT) begin
                        m_v[int'(i_id)] = 1'b1;
                        m_s[int'(i_id)] = int'(i_start_addr);
                        m_e[int'(i_id)] = int'(i_end_addr);
                        if (i_end_addr > i_start_addr) begin
                            if (int'(i_start_addr) < m_lo) m_lo = int'(i_start_addr);
                            if (int'(i_end_addr) > m_hi)   m_hi = int'(i_end_addr);
                        end
                    end
                    if (i_route_en) begin
                        if (m_lo >= m_hi) begin
                            m_phase = PH_READY;
                        end else begin
                            m_phase = PH_SCAN;
                            m_c = 0;
                            m_len = m_hi - m_lo;
                            model_fill();
                        end
                    end
                end
                PH_SCAN: begin
                    m_c++;
                    if (m_c == m_len + 1) m_phase = PH_READY;
                end
                default: begin
                    all_empty = 1'b1;
                    for (int k = 0; k < COUNT; k++) if (m_q[k].size() != 0) all_empty = 1'b0;
                    if (i_pop_en) begin
                        for (int k = 0; k < COUNT; k++) begin
                            if (m_q[k].size() != 0) begin
                                e_valid[k] = 1'b1;
                                e_data[k] = m_q[k].pop_front();
                            end
                        end
                    end
                    if (all_empty) m_phase = PH_IDLE;
                end
            endcase
        end
        e_re   = (m_phase == PH_SCAN) && (m_c < m_len);
        e_addr = m_lo + m_c;
    end

    function automatic bit exp_empty();
        bit r = 1'b1;
        for (int k = 0; k < COUNT; k++) begin
            int sz = m_q[k].size();
            if (m_phase == PH_READY && i_pop_en && sz > 0) sz--;
            if (sz != 0) r = 1'b0;
        end
        return r;
    endfunction

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge i_clk) begin
        if (chk_en && i_nrst) begin
            check("sram_re", o_sram_re, e_re);
            if (e_re) check("sram_addr", o_sram_addr, e_addr[AW-1:0]);
            check("pop_ready", o_fifo_pop_ready, m_phase == PH_READY);
            check("valid", o_valid, e_valid);
            for (int k = 0; k < COUNT; k++) begin
                if (e_valid[k]) check("lane_data", o_data[k*DW +: DW], e_data[k]);
            end
            if (m_phase != PH_SCAN) begin
                check("fifo_empty", o_fifo_empty, exp_empty());
                check("overflow", o_overflow, m_ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_win(input int id, input int s, input int e);
        i_addr_write_en = 1'b1;
        i_id = id[COUNT-1:0];
        i_start_addr = s[AW-1:0];
        i_end_addr = e[AW-1:0];
        step();
        i_addr_write_en = 1'b0;
    endtask

    task automatic do_clear();
        i_reg_clear = 1'b1;
        step();
        i_reg_clear = 1'b0;
    endtask

    // Returns the number of clock edges from the route_en sample until pop_ready is seen.
    task automatic run_scan(input bit rnd_pop, output int cyc);
        i_route_en = 1'b1;
        i_pop_en = rnd_pop ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        i_route_en = 1'b0;
        cyc = 1;
        while (!o_fifo_pop_ready && cyc < 400) begin
            i_pop_en = rnd_pop ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            cyc++;
        end
        i_pop_en = 1'b0;
        if (!o_fifo_pop_ready) check("scan_timeout", o_fifo_pop_ready, 1'b1);
    endtask

    task automatic drain(input bit rnd_pop);
        int n = 0;
        while (o_fifo_pop_ready && n < 300) begin
            i_pop_en = rnd_pop ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        i_pop_en = 1'b0;
        check("drain_done", o_fifo_pop_ready, 1'b0);
    endtask

    initial begin
        int cyc;
        int n;
        for (int a = 0; a < 256; a++) mem[a] = a[DW-1:0];
        repeat (3) @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
        chk_en = 1'b1;

        // Reset state
        check("rst_pop_ready", o_fifo_pop_ready, 1'b0);
        check("rst_empty", o_fifo_empty, 1'b1);
        check("rst_sram_re", o_sram_re, 1'b0);
        check("rst_valid", o_valid, '0);
        check("rst_data", o_data, '0);
        check("rst_overflow", o_overflow, 1'b0);

        // Four disjoint windows over SRAM[a]=a
        set_win(0, 0, 4); set_win(1, 4, 8); set_win(2, 8, 12); set_win(3, 12, 16);
        run_scan(1'b0, cyc);
        check("t1_ready_cycles", cyc, 18);
        for (int j = 0; j < 4; j++) begin
            i_pop_en = 1'b1;
            check("t1_empty_before_pop", o_fifo_empty, j == 3);
            step();
            check("t1_valid", o_valid, 4'hF);
            for (int k = 0; k < COUNT; k++) check("t1_lane_word", o_data[k*DW +: DW], 4*k + j);
        end
        i_pop_en = 1'b0;
        step(); step();
        check("t1_back_idle", o_fifo_pop_ready, 1'b0);

        // Overlapping windows
        do_clear();
        set_win(0, 2, 6); set_win(1, 4, 8);
        run_scan(1'b0, cyc);
        check("t2_ready_cycles", cyc, 8);
        for (int j = 0; j < 4; j++) begin
            i_pop_en = 1'b1;
            step();
            check("t2_valid", o_valid, 4'b0011);
            check("t2_lane0", o_data[0 +: DW], 2 + j);
            check("t2_lane1", o_data[DW +: DW], 4 + j);
        end
        drain(1'b0);

        // Empty table
        do_clear();
        run_scan(1'b0, cyc);
        check("t3_ready_cycles", cyc, 1);
        check("t3_empty", o_fifo_empty, 1'b1);
        check("t3_no_read", o_sram_re, 1'b0);
        drain(1'b0);

        // Overflow on a 20-word window into a 16-deep lane
        do_clear();
        set_win(0, 0, 20);
        run_scan(1'b0, cyc);
        check("t4_ready_cycles", cyc, 22);
        check("t4_overflow", o_overflow, 1'b1);
        for (int j = 0; j < DEPTH; j++) begin
            i_pop_en = 1'b1;
            step();
            check("t4_valid", o_valid, 4'b0001);
            check("t4_lane0", o_data[0 +: DW], j);
        end
        i_pop_en = 1'b0;
        check("t4_empty", o_fifo_empty, 1'b1);
        step(); step();
        check("t4_overflow_sticky", o_overflow, 1'b1);
        do_clear();
        check("t4_overflow_cleared", o_overflow, 1'b0);

        // Clear in the middle of a scan
        set_win(0, 0, 4); set_win(1, 4, 8); set_win(2, 8, 12); set_win(3, 12, 16);
        i_route_en = 1'b1;
        step();
        i_route_en = 1'b0;
        n = 0;
        while (!(o_sram_re && o_sram_addr == 8'd5) && n < 20) begin step(); n++; end
        check("t5_at_addr5", o_sram_addr, 8'd5);
        do_clear();
        check("t5_sram_re", o_sram_re, 1'b0);
        check("t5_empty", o_fifo_empty, 1'b1);
        check("t5_pop_ready", o_fifo_pop_ready, 1'b0);
        run_scan(1'b0, cyc);
        check("t5_windows_invalid", cyc, 1);
        drain(1'b0);

        // Writes with an out-of-range id, and writes during a scan, are ignored
        do_clear();
        set_win(0, 0, 4); set_win(1, 4, 8); set_win(COUNT, 0, 200);
        i_route_en = 1'b1;
        step();
        i_route_en = 1'b0;
        i_addr_write_en = 1'b1; i_id = 2; i_start_addr = 0; i_end_addr = 100;
        step(); step(); step();
        i_addr_write_en = 1'b0;
        n = 0;
        while (!o_fifo_pop_ready && n < 50) begin step(); n++; end
        check("t6_ready", o_fifo_pop_ready, 1'b1);
        for (int j = 0; j < 4; j++) begin
            i_pop_en = 1'b1;
            step();
            check("t6_valid", o_valid, 4'b0011);
            check("t6_lane0", o_data[0 +: DW], j);
            check("t6_lane1", o_data[DW +: DW], 4 + j);
        end
        drain(1'b0);
        run_scan(1'b0, cyc);
        check("t6_table_kept", cyc, 10);
        drain(1'b0);

        // Randomized tables, SRAM contents and pop patterns
        for (int it = 0; it < 30; it++) begin
            int nw;
            int exp_cyc;
            if (it % 3 == 0) do_clear();
            for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                int s;
                int e;
                s = $urandom_range(0, 40);
                e = s + int'($urandom_range(0, 24)) - 3;
                if (e < 0) e = 0;
                set_win($urandom_range(0, COUNT), s, e);
            end
            exp_cyc = (m_lo >= m_hi) ? 1 : (m_hi - m_lo + 2);
            run_scan(1'b1, cyc);
            check("rnd_ready_cycles", cyc, exp_cyc);
            drain(1'b1);
        end

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
